// File: rtl/systolic_mm_array.sv
// systolic_mm_array: output-stationary NxN systolic matrix multiplier C = A x B.
// One operand beat per accepted handshake carries column k of A and row k of B.
// After K beats and a (2N-1)-cycle drain, C streams out row-major.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start, i_k_len          job request and inner dimension K (sampled in IDLE)
//   i_a_col, i_b_row          operand lanes (lane i = A[i][k], lane j = B[k][j])
//   i_in_valid / o_in_ready   operand beat handshake
//   o_res_data/row/col        result C[row][col]
//   o_res_valid / i_res_ready result handshake
//   o_busy, o_done            job active, one-cycle completion pulse
module systolic_mm_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 3,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned SIGNED     = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [7:0]              i_k_len,
    input  logic [N*DATA_WIDTH-1:0] i_a_col,
    input  logic [N*DATA_WIDTH-1:0] i_b_row,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    output logic [ACC_WIDTH-1:0]    o_res_data,
    output logic [$clog2(N)-1:0]    o_res_row,
    output logic [$clog2(N)-1:0]    o_res_col,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int unsigned PW         = 2 * DATA_WIDTH;
    localparam int unsigned IDX_W      = $clog2(N);
    localparam int unsigned DRAIN_LAST = 2 * N - 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]           r_state, w_state_nxt;
    logic [7:0]           r_k_len, r_cnt;
    logic                 r_in_ready, r_res_valid, r_busy, r_done;
    logic [ACC_WIDTH-1:0] r_res_data;
    logic [IDX_W-1:0]     r_row, r_col, w_nxt_row, w_nxt_col;
    logic                 w_start_ok, w_beat, w_res_hs, w_res_last;

    logic [DATA_WIDTH-1:0] w_a_inj  [N];
    logic [DATA_WIDTH-1:0] w_b_inj  [N];
    logic [DATA_WIDTH-1:0] w_a_skew [N];
    logic [DATA_WIDTH-1:0] w_b_skew [N];
    logic [DATA_WIDTH-1:0] r_pa     [N][N];
    logic [DATA_WIDTH-1:0] r_pb     [N][N];
    logic [DATA_WIDTH-1:0] w_pa_in  [N][N];
    logic [DATA_WIDTH-1:0] w_pb_in  [N][N];
    logic [ACC_WIDTH-1:0]  r_acc    [N][N];

    // Extend operands to product width, multiply, then extend product to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] f_prod(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        logic [PW-1:0] ea, eb, p;
        if (SIGNED != 0) begin
            ea = PW'($signed(a));
            eb = PW'($signed(b));
            p  = ea * eb;
            return ACC_WIDTH'($signed(p));
        end else begin
            ea = PW'(a);
            eb = PW'(b);
            p  = ea * eb;
            return ACC_WIDTH'(p);
        end
    endfunction

    assign w_start_ok = (r_state == S_IDLE) && i_start && (i_k_len != 8'd0);
    assign w_beat     = r_in_ready && i_in_valid;
    assign w_res_hs   = r_res_valid && i_res_ready;
    assign w_res_last = (r_row == IDX_W'(N - 1)) && (r_col == IDX_W'(N - 1));
    assign w_nxt_col  = (r_col == IDX_W'(N - 1)) ? '0 : r_col + IDX_W'(1);
    assign w_nxt_row  = (r_col == IDX_W'(N - 1)) ? r_row + IDX_W'(1) : r_row;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_FEED;
            S_FEED:  if (w_beat && (r_cnt == r_k_len - 8'd1)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_cnt == 8'(DRAIN_LAST)) w_state_nxt = S_OUT;
            S_OUT:   if (w_res_hs && w_res_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters and status outputs (decoded from next state so they are registered)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_k_len     <= 8'd0;
            r_cnt       <= 8'd0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_FEED);
            r_res_valid <= (w_state_nxt == S_OUT);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (r_state == S_OUT) && (w_state_nxt == S_IDLE);
            if (w_start_ok) r_k_len <= i_k_len;
            // r_cnt counts accepted beats in FEED and cycles in DRAIN
            if (w_state_nxt != r_state) r_cnt <= 8'd0;
            else if (w_beat || (r_state == S_DRAIN)) r_cnt <= r_cnt + 8'd1;
        end
    end

    // Result register: loaded with C[0][0] on OUT entry, advanced on each handshake
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_res_data <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else if ((r_state == S_DRAIN) && (w_state_nxt == S_OUT)) begin
            r_res_data <= r_acc[0][0];
            r_row      <= '0;
            r_col      <= '0;
        end else if (w_res_hs) begin
            if (w_res_last) begin
                r_res_data <= '0;
                r_row      <= '0;
                r_col      <= '0;
            end else begin
                r_res_data <= r_acc[w_nxt_row][w_nxt_col];
                r_row      <= w_nxt_row;
                r_col      <= w_nxt_col;
            end
        end
    end

    // Lanes carry zero (bubble) whenever no beat is accepted
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_inj[i] = w_beat ? i_a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            w_b_inj[i] = w_beat ? i_b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // Input skew: lane g is delayed g cycles so operands meet in PE(i,j) together
    for (genvar g = 0; g < N; g++) begin : g_skew
        if (g == 0) begin : g_direct
            assign w_a_skew[g] = w_a_inj[g];
            assign w_b_skew[g] = w_b_inj[g];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_sa [g];
            logic [DATA_WIDTH-1:0] r_sb [g];
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int s = 0; s < g; s++) begin
                        r_sa[s] <= '0;
                        r_sb[s] <= '0;
                    end
                end else begin
                    r_sa[0] <= w_a_inj[g];
                    r_sb[0] <= w_b_inj[g];
                    for (int s = 1; s < g; s++) begin
                        r_sa[s] <= r_sa[s-1];
                        r_sb[s] <= r_sb[s-1];
                    end
                end
            end
            assign w_a_skew[g] = r_sa[g-1];
            assign w_b_skew[g] = r_sb[g-1];
        end
    end

    // PE operand inputs: A flows rightward, B flows downward
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_pa_in[i][0] = w_a_skew[i];
            w_pb_in[0][i] = w_b_skew[i];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                w_pa_in[i][j] = r_pa[i][j-1];
                w_pb_in[j][i] = r_pb[j-1][i];
            end
        end
    end

    // PE array: forward operands and accumulate every cycle
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!i_rst_n) begin
                    r_pa[i][j]  <= '0;
                    r_pb[i][j]  <= '0;
                    r_acc[i][j] <= '0;
                end else begin
                    r_pa[i][j] <= w_pa_in[i][j];
                    r_pb[i][j] <= w_pb_in[i][j];
                    if (w_start_ok) r_acc[i][j] <= '0;
                    else r_acc[i][j] <= r_acc[i][j] + f_prod(w_pa_in[i][j], w_pb_in[i][j]);
                end
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_res_data  = r_res_data;
    assign o_res_row   = r_row;
    assign o_res_col   = r_col;
    assign o_res_valid = r_res_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_systolic_mm_array.sv
// Self-checking bench for systolic_mm_array (N=3, 8-bit operands, 20-bit results).
// Two instances share stimulus: u_dut unsigned, s_dut signed.
module tb_systolic_mm_array;

    typedef struct packed {
        logic [7:0]             k;
        logic                   sgn;
        logic                   in_stall;
        logic                   out_stall;
        logic                   poke;
        logic                   timing;
        logic                   fill;
        logic [7:0]             fa;
        logic [7:0]             fb;
        logic [2:0][2:0][7:0]   a;   // a[i][k]
        logic [2:0][2:0][7:0]   b;   // b[k][j]
        logic [8:0][19:0]       c;   // row-major expected C
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, res_ready;
    logic [7:0]  k_len;
    logic [23:0] a_col, b_row;

    logic        u_in_ready, u_res_valid, u_busy, u_done;
    logic [19:0] u_res_data;
    logic [1:0]  u_row, u_col;
    logic        s_in_ready, s_res_valid, s_busy, s_done;
    logic [19:0] s_res_data;
    logic [1:0]  s_row, s_col;

    logic        sel;
    logic        in_ready, res_valid, busy, done;
    logic [19:0] res_data;
    logic [1:0]  row, col;

    int   n_checks = 0;
    int   n_pass   = 0;
    job_t jobs [8];

    always #5 clk = ~clk;

    systolic_mm_array #(.DATA_WIDTH(8), .N(3), .ACC_WIDTH(20), .SIGNED(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_len(k_len),
        .i_a_col(a_col), .i_b_row(b_row), .i_in_valid(in_valid), .o_in_ready(u_in_ready),
        .o_res_data(u_res_data), .o_res_row(u_row), .o_res_col(u_col),
        .o_res_valid(u_res_valid), .i_res_ready(res_ready), .o_busy(u_busy), .o_done(u_done)
    );

    systolic_mm_array #(.DATA_WIDTH(8), .N(3), .ACC_WIDTH(20), .SIGNED(1)) s_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_len(k_len),
        .i_a_col(a_col), .i_b_row(b_row), .i_in_valid(in_valid), .o_in_ready(s_in_ready),
        .o_res_data(s_res_data), .o_res_row(s_row), .o_res_col(s_col),
        .o_res_valid(s_res_valid), .i_res_ready(res_ready), .o_busy(s_busy), .o_done(s_done)
    );

    assign in_ready  = sel ? s_in_ready  : u_in_ready;
    assign res_valid = sel ? s_res_valid : u_res_valid;
    assign busy      = sel ? s_busy      : u_busy;
    assign done      = sel ? s_done      : u_done;
    assign res_data  = sel ? s_res_data  : u_res_data;
    assign row       = sel ? s_row       : u_row;
    assign col       = sel ? s_col       : u_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_job(input int j);
        int          cyc, beats, oidx, done_cyc;
        bit          stalled, rdy;
        logic [19:0] h_data;
        logic [1:0]  h_row, h_col;
        sel = jobs[j].sgn;
        @(negedge clk);
        start = 1'b1;
        k_len = jobs[j].k;
        @(negedge clk);
        start = 1'b0;
        k_len = 8'd0;
        check($sformatf("job%0d busy_after_start", j), 32'(busy), 32'd1);
        check($sformatf("job%0d in_ready_after_start", j), 32'(in_ready), 32'd1);
        cyc = 1; beats = 0; oidx = 0; done_cyc = 0; stalled = 1'b0;
        while (cyc < 400 && done_cyc == 0) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (stalled) begin
                    check($sformatf("job%0d hold_valid", j), 32'(res_valid), 32'd1);
                    check($sformatf("job%0d hold_data", j), 32'(res_data), 32'(h_data));
                    check($sformatf("job%0d hold_row", j), 32'(row), 32'(h_row));
                    check($sformatf("job%0d hold_col", j), 32'(col), 32'(h_col));
                end
                stalled  = 1'b0;
                in_valid = 1'b0;
                a_col    = 24'($urandom);
                b_row    = 24'($urandom);
                if (in_ready && beats < int'(jobs[j].k) && (!jobs[j].in_stall || (cyc % 2 == 0))) begin
                    for (int i = 0; i < 3; i++) begin
                        a_col[i*8 +: 8] = jobs[j].fill ? jobs[j].fa : jobs[j].a[i][beats];
                        b_row[i*8 +: 8] = jobs[j].fill ? jobs[j].fb : jobs[j].b[beats][i];
                    end
                    in_valid = 1'b1;
                    beats++;
                end
                start     = jobs[j].poke && (cyc % 3 == 1);
                k_len     = 8'd1;
                rdy       = !jobs[j].out_stall || (cyc % 2 == 1);
                res_ready = rdy;
                if (res_valid) begin
                    if (rdy) begin
                        if (oidx < 9) begin
                            check($sformatf("job%0d data[%0d]", j, oidx), 32'(res_data), 32'(jobs[j].c[oidx]));
                            check($sformatf("job%0d row[%0d]", j, oidx), 32'(row), 32'(oidx / 3));
                            check($sformatf("job%0d col[%0d]", j, oidx), 32'(col), 32'(oidx % 3));
                        end
                        oidx++;
                    end else begin
                        stalled = 1'b1;
                        h_data  = res_data;
                        h_row   = row;
                        h_col   = col;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; k_len = 8'd0; in_valid = 1'b0; res_ready = 1'b0;
        check($sformatf("job%0d done_seen", j), 32'(done_cyc != 0), 32'd1);
        check($sformatf("job%0d result_count", j), 32'(oidx), 32'd9);
        if (jobs[j].timing)
            check($sformatf("job%0d done_cycle", j), 32'(done_cyc), 32'(int'(jobs[j].k) + 15));
        @(negedge clk);
        check($sformatf("job%0d done_one_cycle", j), 32'(done), 32'd0);
        check($sformatf("job%0d busy_idle", j), 32'(busy), 32'd0);
        check($sformatf("job%0d res_valid_idle", j), 32'(res_valid), 32'd0);
    endtask

    task automatic set_c(input int j, input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int v6, input int v7, input int v8);
        jobs[j].c[0] = 20'(v0); jobs[j].c[1] = 20'(v1); jobs[j].c[2] = 20'(v2);
        jobs[j].c[3] = 20'(v3); jobs[j].c[4] = 20'(v4); jobs[j].c[5] = 20'(v5);
        jobs[j].c[6] = 20'(v6); jobs[j].c[7] = 20'(v7); jobs[j].c[8] = 20'(v8);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcount;
        for (int j = 0; j < 8; j++) jobs[j] = '0;

        // 0: identity x [1..9]
        jobs[0].k = 8'd3; jobs[0].timing = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int m = 0; m < 3; m++) begin
                jobs[0].a[i][m] = (i == m) ? 8'd1 : 8'd0;
                jobs[0].b[i][m] = 8'(3 * i + m + 1);
            end
        set_c(0, 1, 2, 3, 4, 5, 6, 7, 8, 9);
        // 1: all 255 unsigned
        jobs[1].k = 8'd3; jobs[1].timing = 1'b1; jobs[1].fill = 1'b1;
        jobs[1].fa = 8'hFF; jobs[1].fb = 8'hFF;
        set_c(1, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075);
        // 2: all -128 signed
        jobs[2].k = 8'd3; jobs[2].timing = 1'b1; jobs[2].fill = 1'b1; jobs[2].sgn = 1'b1;
        jobs[2].fa = 8'h80; jobs[2].fb = 8'h80;
        set_c(2, 49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152);
        // 3: job 0 with input bubbles and output backpressure
        jobs[3] = jobs[0];
        jobs[3].timing = 1'b0; jobs[3].in_stall = 1'b1; jobs[3].out_stall = 1'b1;
        // 4: K=20 all 255 -> 1300500 mod 2^20
        jobs[4].k = 8'd20; jobs[4].timing = 1'b1; jobs[4].fill = 1'b1;
        jobs[4].fa = 8'hFF; jobs[4].fb = 8'hFF;
        set_c(4, 251924, 251924, 251924, 251924, 251924, 251924, 251924, 251924, 251924);
        // 5: general matrices, with stray i_start during the job
        jobs[5].k = 8'd3; jobs[5].timing = 1'b1; jobs[5].poke = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int m = 0; m < 3; m++) begin
                jobs[5].a[i][m] = 8'(3 * i + m + 1);
                jobs[5].b[i][m] = 8'(9 - (3 * i + m));
            end
        set_c(5, 30, 24, 18, 84, 69, 54, 138, 114, 90);
        // 6: K=2; third A column / B row must never be consumed
        jobs[6].k = 8'd2; jobs[6].timing = 1'b1;
        jobs[6].a[0] = {8'd9, 8'd2, 8'd1};
        jobs[6].a[1] = {8'd9, 8'd4, 8'd3};
        jobs[6].a[2] = {8'd9, 8'd6, 8'd5};
        jobs[6].b[0] = {8'd2, 8'd0, 8'd1};
        jobs[6].b[1] = {8'd3, 8'd1, 8'd0};
        jobs[6].b[2] = {8'd9, 8'd9, 8'd9};
        set_c(6, 1, 2, 8, 3, 4, 18, 5, 6, 28);
        // 7: signed -1 x 2, K=3 -> -6 mod 2^20
        jobs[7].k = 8'd3; jobs[7].timing = 1'b1; jobs[7].fill = 1'b1; jobs[7].sgn = 1'b1;
        jobs[7].fa = 8'hFF; jobs[7].fb = 8'h02;
        set_c(7, 1048570, 1048570, 1048570, 1048570, 1048570, 1048570, 1048570, 1048570, 1048570);

        rst_n = 1'b0; start = 1'b0; k_len = 8'd0; a_col = '0; b_row = '0;
        in_valid = 1'b0; res_ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(u_busy), 32'd0);
        check("reset in_ready", 32'(u_in_ready), 32'd0);
        check("reset res_valid", 32'(u_res_valid), 32'd0);
        check("reset done", 32'(u_done), 32'd0);
        check("reset res_data", 32'(u_res_data), 32'd0);
        check("reset row_col", 32'({u_row, u_col}), 32'd0);
        check("reset signed busy", 32'(s_busy), 32'd0);
        rst_n = 1'b1;

        run_job(0);
        run_job(1);
        run_job(2);
        run_job(7);
        run_job(3);
        run_job(4);
        run_job(5);

        // i_start with K=0 is ignored
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1; k_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("k0 busy", 32'(busy), 32'd0);
        check("k0 in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("k0 busy_later", 32'(busy), 32'd0);

        // Reset mid-FEED aborts the job without o_done
        start = 1'b1; k_len = 8'd3;
        @(negedge clk);
        start = 1'b0; k_len = 8'd0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a_col = 24'h030201; b_row = 24'h060504;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort in_ready_low", 32'(in_ready), 32'd0);
        check("abort res_valid", 32'(res_valid), 32'd0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) dcount++;
            @(negedge clk);
        end
        check("abort no_done_no_busy", 32'(dcount), 32'd0);

        run_job(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
